rr_mux: RTL and testbench



---
 rtl/rr_mux.sv | 204 ++++++++++++++++++++
 tb/tb_rr_mux.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux.sv
// rr_mux: round-robin arbitrated N-to-1 multiplexer with valid/ready
// handshakes on every source and a single registered output stage.
// Each output beat carries out_sel, the index of the source that won,
// so the far end can route a response back to its origin.
//
// Build option: define RR_MUX_BURST_LOCK_EN to keep the grant on a source
// from its first beat until the beat carrying in_last is accepted. With the
// macro undefined, arbitration happens on every beat and in_last is only
// forwarded to out_last. The port list is the same in both builds.
module rr_mux #(
  parameter int NUM_ELEM   = 8,
  parameter int ELEM_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                arst_n,
  input  logic [NUM_ELEM-1:0]                 in_valid,
  input  logic [NUM_ELEM-1:0]                 in_last,
  input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] in_data,
  output logic [NUM_ELEM-1:0]                 in_ready,
  output logic                                out_valid,
  output logic [ELEM_WIDTH-1:0]               out_data,
  output logic                                out_last,
  output logic [$clog2(NUM_ELEM)-1:0]         out_sel,
  input  logic                                out_ready
);

  localparam int SEL_W = $clog2(NUM_ELEM);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_ELEM - 1);

  // Registered output stage
  logic                  out_valid_q, out_valid_d;
  logic [ELEM_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_last_q,  out_last_d;
  logic [SEL_W-1:0]      out_sel_q,   out_sel_d;

  // Round-robin priority pointer: the search for a winner starts here
  logic [SEL_W-1:0]      ptr_q, ptr_d;

  // Arbitration and handshake results for the current cycle
  logic                  rr_found;
  logic [SEL_W-1:0]      rr_idx;
  logic [SEL_W-1:0]      cand_idx;
  logic                  grant_found;
  logic [SEL_W-1:0]      grant_idx;
  logic                  load_en;
  logic                  accept;

`ifdef RR_MUX_BURST_LOCK_EN
  // While locked, the grant is pinned to lock_idx until its last beat
  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e           lock_state_q, lock_state_d;
  logic [SEL_W-1:0]      lock_idx_q,   lock_idx_d;
`endif

  // Successor of an index, wrapping NUM_ELEM-1 back to 0 (works for any
  // NUM_ELEM, not only powers of two)
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
  endfunction

  // base + off modulo NUM_ELEM, with off < NUM_ELEM and base < NUM_ELEM
  function automatic logic [SEL_W-1:0] offset_idx(input logic [SEL_W-1:0] base,
                                                  input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_ELEM)) begin
      sum = sum - 32'(NUM_ELEM);
    end
    return SEL_W'(sum);
  endfunction

  // Round-robin search: first valid source at or after ptr, wrapping around
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand_idx = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      cand_idx = offset_idx(ptr_q, unsigned'(k));
      if (!rr_found && in_valid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // Final grant: a held burst lock overrides the round-robin winner, even
  // when the locked source currently has no beat to offer
  always_comb begin
    grant_found = rr_found;
    grant_idx   = rr_idx;
`ifdef RR_MUX_BURST_LOCK_EN
    if (lock_state_q == ARB_LOCKED) begin
      grant_found = 1'b1;
      grant_idx   = lock_idx_q;
    end
`endif
  end

  // Handshake: the output register can load when empty or being drained;
  // in_ready is forced low while reset is asserted
  always_comb begin
    load_en  = ~out_valid_q | out_ready;
    in_ready = '0;
    if (arst_n && grant_found && load_en) begin
      in_ready[grant_idx] = 1'b1;
    end
    accept = arst_n & grant_found & load_en & in_valid[grant_idx];
  end

  // Output register next state: load on accept, empty on drain, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant_idx];
      out_last_d  = in_last[grant_idx];
      out_sel_d   = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer (and lock) next state: the pointer moves past the winner once
  // its transfer is complete, so the winner becomes lowest priority
  always_comb begin
    ptr_d = ptr_q;
`ifdef RR_MUX_BURST_LOCK_EN
    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx_q;
    if (accept) begin
      if (in_last[grant_idx]) begin
        lock_state_d = ARB_FREE;
        ptr_d        = next_idx(grant_idx);
      end else begin
        lock_state_d = ARB_LOCKED;
        lock_idx_d   = grant_idx;
      end
    end
`else
    if (accept) begin
      ptr_d = next_idx(grant_idx);
    end
`endif
  end

  // Output stage flops; reset drops any held beat immediately
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  // Arbitration pointer flop; restarts the search at source 0 after reset
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifdef RR_MUX_BURST_LOCK_EN
  // Burst lock flops; reset abandons any burst in progress
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lock_state_q <= ARB_FREE;
      lock_idx_q   <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

  // At most one source may ever see in_ready
  a_ready_onehot: assert property (@(posedge clk) disable iff (!arst_n)
    $onehot0(in_ready));

  // A beat that is not taken downstream must stay put
  a_hold_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (out_valid_q && !out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_sel_q) && $stable(out_last_q)));

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: self-checking bench for rr_mux with NUM_ELEM = 4.
// A behavioural model (pointer as an integer, search by modular arithmetic,
// output register as plain variables) predicts in_ready and the outputs every
// cycle; directed scenarios add fixed expected out_sel/out_data sequences.
// Follows RR_MUX_BURST_LOCK_EN the same way the design does.
module tb_rr_mux;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 arst_n;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_last;
  logic [N-1:0][W-1:0]  in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic                 out_last;
  logic [SW-1:0]        out_sel;
  logic                 out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mdl_ptr;
  bit          mdl_locked;
  int          mdl_lock_src;
  bit          mdl_valid;
  logic [W-1:0] mdl_data;
  bit          mdl_last;
  int          mdl_sel;
  int          mdl_acc_src;

  int fair_seq[6] = '{0, 1, 2, 3, 0, 1};
`ifdef RR_MUX_BURST_LOCK_EN
  localparam int BURST_LEN = 4;
  int burst_seq[BURST_LEN] = '{1, 1, 1, 2};
`else
  localparam int BURST_LEN = 5;
  int burst_seq[BURST_LEN] = '{1, 2, 1, 2, 1};
`endif

  always #5 clk = ~clk;

  rr_mux #(.NUM_ELEM(N), .ELEM_WIDTH(W)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] last,
                               input logic ready);
    in_valid  = valid;
    in_last   = last;
    out_ready = ready;
  endtask

  task automatic modelReset();
    mdl_ptr      = 0;
    mdl_locked   = 0;
    mdl_lock_src = 0;
    mdl_valid    = 0;
    mdl_data     = '0;
    mdl_last     = 0;
    mdl_sel      = 0;
    mdl_acc_src  = -1;
  endtask

  // Winner under the arbitration rules, or -1 when nobody is granted
  function automatic int modelGrant();
    if (mdl_locked) return mdl_lock_src;
    for (int k = 0; k < N; k++) begin
      if (in_valid[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: compare against the model mid-cycle, then advance it
  task automatic stepCycle();
    int           g;
    bit           load;
    bit           acc;
    logic [N-1:0] exp_ready;
    logic [W-1:0] acc_data;
    bit           acc_last;
    @(negedge clk);
    g         = modelGrant();
    load      = !mdl_valid || out_ready;
    exp_ready = '0;
    if (g >= 0 && load) exp_ready[g] = 1'b1;
    acc       = (g >= 0) && load && in_valid[g];
    acc_data  = (g >= 0) ? in_data[g] : '0;
    acc_last  = (g >= 0) ? in_last[g] : 1'b0;
    checkOutput("in_ready",  64'(in_ready),  64'(exp_ready));
    checkOutput("out_valid", 64'(out_valid), 64'(mdl_valid));
    checkOutput("out_data",  64'(out_data),  64'(mdl_data));
    checkOutput("out_last",  64'(out_last),  64'(mdl_last));
    checkOutput("out_sel",   64'(out_sel),   64'(mdl_sel));
    @(posedge clk);
    #1;
    mdl_acc_src = -1;
    if (acc) begin
      mdl_acc_src = g;
      mdl_valid   = 1;
      mdl_data    = acc_data;
      mdl_last    = acc_last;
      mdl_sel     = g;
`ifdef RR_MUX_BURST_LOCK_EN
      if (acc_last) begin
        mdl_locked = 0;
        mdl_ptr    = (g + 1) % N;
      end else begin
        mdl_locked   = 1;
        mdl_lock_src = g;
      end
`else
      mdl_ptr = (g + 1) % N;
`endif
    end else if (out_ready) begin
      mdl_valid = 0;
    end
  endtask

  // Asynchronous reset away from clock edges, all sources requesting;
  // checks reset values without an edge and the first grant after release
  task automatic applyReset();
    @(negedge clk);
    #2;
    in_valid = '1;
    arst_n   = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
    checkOutput("rst_out_sel",   64'(out_sel),   64'd0);
    checkOutput("rst_out_data",  64'(out_data),  64'd0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_ready", 64'(in_ready), 64'd0);
    #2;
    arst_n = 1'b1;
    #1;
    checkOutput("rst_first_grant", 64'(in_ready), 64'b0001);
  endtask

  initial begin
    int b1;
    arst_n    = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    modelReset();

    // Fairness: every source valid, downstream always ready
    applyReset();
    for (int i = 0; i < N; i++) in_data[i] = W'(32'hF0 + i);
    applyStimulus('1, '1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      stepCycle();
      checkOutput("fair_sel", 64'(out_sel), 64'(fair_seq[k]));
    end
    applyStimulus('0, '0, 1'b1);
    stepCycle();

    // Single source, two back-to-back beats
    applyReset();
    in_data[3] = 32'hA0;
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    stepCycle();
    checkOutput("single_data0", 64'(out_data), 64'hA0);
    checkOutput("single_sel0",  64'(out_sel),  64'd3);
    in_data[3] = 32'hA1;
    applyStimulus(4'b1000, 4'b1000, 1'b1);
    stepCycle();
    checkOutput("single_data1",  64'(out_data),  64'hA1);
    checkOutput("single_sel1",   64'(out_sel),   64'd3);
    checkOutput("single_valid1", 64'(out_valid), 64'd1);
    applyStimulus('0, '0, 1'b1);
    stepCycle();

    // Backpressure: 0x55 held for three cycles, then 0x66 follows
    applyReset();
    in_data[0] = 32'h55;
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    stepCycle();
    checkOutput("bp_data", 64'(out_data), 64'h55);
    in_data[1] = 32'h66;
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("bp_hold_data",  64'(out_data), 64'h55);
      checkOutput("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    stepCycle();
    checkOutput("bp_next_data", 64'(out_data), 64'h66);
    checkOutput("bp_next_sel",  64'(out_sel),  64'd1);
    applyStimulus('0, '0, 1'b1);
    stepCycle();

    // Burst of three from source 1 while source 2 keeps requesting
    applyReset();
    b1 = 0;
    in_data[2] = 32'h200;
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    for (int k = 0; k < BURST_LEN; k++) begin
      in_valid[1] = (b1 < 3);
      in_data[1]  = W'(32'h100 + b1);
      in_last[1]  = (b1 == 2);
      stepCycle();
      checkOutput("burst_sel", 64'(out_sel), 64'(burst_seq[k]));
      if (mdl_acc_src == 1) b1++;
    end
    applyStimulus('0, '0, 1'b1);
    stepCycle();

`ifdef RR_MUX_BURST_LOCK_EN
    // Locked source pauses mid-burst; the other source must keep waiting
    applyReset();
    in_data[1] = 32'h100;
    in_data[2] = 32'h200;
    applyStimulus(4'b0110, 4'b0100, 1'b1);
    stepCycle();
    checkOutput("lock_first_sel", 64'(out_sel), 64'd1);
    in_valid[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      stepCycle();
      checkOutput("lock_wait_ready2", 64'(in_ready[2]), 64'd0);
      checkOutput("lock_wait_valid",  64'(out_valid),   64'd0);
    end
    in_data[1]  = 32'h101;
    in_valid[1] = 1'b1;
    in_last[1]  = 1'b1;
    stepCycle();
    checkOutput("lock_last_sel",  64'(out_sel),  64'd1);
    checkOutput("lock_last_data", 64'(out_data), 64'h101);
    in_valid[1] = 1'b0;
    stepCycle();
    checkOutput("lock_after_sel", 64'(out_sel), 64'd2);
    applyStimulus('0, '0, 1'b1);
    stepCycle();
`endif

    // Reset while a beat is held (and, in the lock build, while locked)
    applyReset();
    in_data[1] = 32'h77;
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    stepCycle();
    checkOutput("mid_out_valid", 64'(out_valid), 64'd1);
    applyReset();

    // Randomized traffic with occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!(in_valid[i] && mdl_acc_src != i)) begin
          in_valid[i] = ($urandom_range(0, 99) < 55);
          in_data[i]  = $urandom;
          in_last[i]  = ($urandom_range(0, 2) == 0);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      stepCycle();
      if (cyc % 1000 == 999) applyReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
